// File: rtl/adder_bist_pkg.sv
// Shared types and defaults for the adder BIST block.
package adder_bist_pkg;

    // Sequencer states
    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StDrive = 3'd1,
        StWait  = 3'd2,
        StCheck = 3'd3,
        StDone  = 3'd4
    } state_e;

    localparam int unsigned DefWidth = 3;
    localparam int unsigned DefLat   = 1;
    localparam int unsigned DefErrW  = 8;

    // Width of a packed {a, b, cin} test vector.
    function automatic int unsigned vec_w(input int unsigned width);
        return 2 * width + 1;
    endfunction

endpackage

// File: rtl/adder_bist_if.sv
// Operand/result link between the BIST (master) and the adder under test (slave).
interface adder_bist_if #(
    parameter int unsigned WIDTH = 3
);
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             op_cin;
    logic [WIDTH-1:0] dut_sum;
    logic             dut_cout;

    modport master (
        output op_a,
        output op_b,
        output op_cin,
        input  dut_sum,
        input  dut_cout
    );

    modport slave (
        input  op_a,
        input  op_b,
        input  op_cin,
        output dut_sum,
        output dut_cout
    );
endinterface

// File: rtl/adder_bist_golden.sv
// Combinational reference adder: full WIDTH+1-bit result, carry in the MSB.
module adder_bist_golden #(
    parameter int unsigned WIDTH = 3
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH:0]   sum
);

    // Zero-extend before adding so the carry is never lost
    always_comb begin
        sum = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    end

endmodule

// File: rtl/adder_bist.sv
// Exhaustive stimulus generator and response checker for the parallel adder.
// Optional first-failure capture is enabled by defining ADDER_BIST_FAIL_CAPTURE_EN.
module adder_bist
    import adder_bist_pkg::*;
#(
    parameter int unsigned WIDTH = DefWidth,
    parameter int unsigned LAT   = DefLat,
    parameter int unsigned ERR_W = DefErrW
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       ena,
    input  logic                       start,
    adder_bist_if.master               dut,
    output logic                       busy,
    output logic                       done,
    output logic                       pass,
    output logic [ERR_W-1:0]           err_cnt,
    output logic [vec_w(WIDTH)-1:0]    vec_idx,
    output logic [vec_w(WIDTH)-1:0]    fail_vec,
    output logic [WIDTH:0]             fail_obs
);

    localparam int unsigned VecW = vec_w(WIDTH);
    // Enough bits to hold LAT-1
    localparam int unsigned CntW = (LAT > 2) ? $clog2(LAT) : 1;
    localparam logic [CntW-1:0]  CntLoad = CntW'((LAT > 0) ? LAT - 1 : 0);
    localparam logic [ERR_W-1:0] ErrMax  = '1;

    state_e           state_q, state_d;
    logic [VecW-1:0]  vec_idx_q, vec_idx_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d, err_inc;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
    logic             op_cin_q, op_cin_d;
    logic             busy_q, busy_d, done_q, done_d, pass_q, pass_d;
    logic [WIDTH:0]   golden, observed;
    logic             mismatch;

    adder_bist_golden #(
        .WIDTH (WIDTH)
    ) u_golden (
        .a   (op_a_q),
        .b   (op_b_q),
        .cin (op_cin_q),
        .sum (golden)
    );

    // Compare and saturating increment; an unknown response falls to the mismatch path
    always_comb begin
        observed = {dut.dut_cout, dut.dut_sum};
        mismatch = 1'b1;
        if (observed == golden) begin
            mismatch = 1'b0;
        end
        err_inc = err_cnt_q;
        if (mismatch && (err_cnt_q != ErrMax)) begin
            err_inc = err_cnt_q + 1'b1;
        end
    end

    // Next-state and output register logic; nothing moves while ena is low
    always_comb begin
        state_d   = state_q;
        vec_idx_d = vec_idx_q;
        err_cnt_d = err_cnt_q;
        cnt_d     = cnt_q;
        op_a_d    = op_a_q;
        op_b_d    = op_b_q;
        op_cin_d  = op_cin_q;
        busy_d    = busy_q;
        done_d    = done_q;
        pass_d    = pass_q;
        if (ena) begin
            unique case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        vec_idx_d = '0;
                        err_cnt_d = '0;
                        busy_d    = 1'b1;
                        done_d    = 1'b0;
                        pass_d    = 1'b0;
                        state_d   = StDrive;
                    end
                end
                StDrive: begin
                    op_a_d   = vec_idx_q[VecW-1 -: WIDTH];
                    op_b_d   = vec_idx_q[1 +: WIDTH];
                    op_cin_d = vec_idx_q[0];
                    cnt_d    = CntLoad;
                    state_d  = (LAT == 0) ? StCheck : StWait;
                end
                StWait: begin
                    if (cnt_q == '0) begin
                        state_d = StCheck;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                StCheck: begin
                    err_cnt_d = err_inc;
                    if (&vec_idx_q) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (err_inc == '0);
                        state_d = StDone;
                    end else begin
                        vec_idx_d = vec_idx_q + 1'b1;
                        state_d   = StDrive;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            vec_idx_q <= '0;
            err_cnt_q <= '0;
            cnt_q     <= '0;
            op_a_q    <= '0;
            op_b_q    <= '0;
            op_cin_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            vec_idx_q <= vec_idx_d;
            err_cnt_q <= err_cnt_d;
            cnt_q     <= cnt_d;
            op_a_q    <= op_a_d;
            op_b_q    <= op_b_d;
            op_cin_q  <= op_cin_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
        end
    end

    assign dut.op_a   = op_a_q;
    assign dut.op_b   = op_b_q;
    assign dut.op_cin = op_cin_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign err_cnt    = err_cnt_q;
    assign vec_idx    = vec_idx_q;

`ifdef ADDER_BIST_FAIL_CAPTURE_EN
    logic            fail_flag_q, fail_flag_d;
    logic [VecW-1:0] fail_vec_q, fail_vec_d;
    logic [WIDTH:0]  fail_obs_q, fail_obs_d;
    logic            run_start;

    assign run_start = start && ((state_q == StIdle) || (state_q == StDone));

    // First mismatch of a run is latched; the sticky flag blocks later ones
    always_comb begin
        fail_flag_d = fail_flag_q;
        fail_vec_d  = fail_vec_q;
        fail_obs_d  = fail_obs_q;
        if (ena) begin
            if (run_start) begin
                fail_flag_d = 1'b0;
                fail_vec_d  = '0;
                fail_obs_d  = '0;
            end else if ((state_q == StCheck) && mismatch && !fail_flag_q) begin
                fail_flag_d = 1'b1;
                fail_vec_d  = vec_idx_q;
                fail_obs_d  = observed;
            end
        end
    end

    // Capture registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fail_flag_q <= 1'b0;
            fail_vec_q  <= '0;
            fail_obs_q  <= '0;
        end else begin
            fail_flag_q <= fail_flag_d;
            fail_vec_q  <= fail_vec_d;
            fail_obs_q  <= fail_obs_d;
        end
    end

    assign fail_vec = fail_vec_q;
    assign fail_obs = fail_obs_q;
`else
    assign fail_vec = '0;
    assign fail_obs = '0;
`endif

endmodule

// File: tb/tb_adder_bist.sv
// Self-checking bench: three BIST instances (LAT 1/0/3) each driving a bench adder model.
module tb_adder_bist;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic ena = 1'b0;
    logic start = 1'b0;
    int   fault_mode = 0;
    int   checks = 0;
    int   failures = 0;

    logic       busy1, done1, pass1, busy0, done0, pass0, busy3, done3, pass3;
    logic [7:0] err1, err0, err3;
    logic [6:0] vec1, vec0, vec3, fvec1, fvec0, fvec3;
    logic [3:0] fobs1, fobs0, fobs3;
    logic [3:0] p1, p2, p3;

    typedef struct {
        int         cyc1;
        int         cyc0;
        int         cyc3;
        int         err;
        bit         pass;
        logic [6:0] fvec;
        logic [3:0] fobs;
    } exp_t;

    exp_t sb[$];

    adder_bist_if #(.WIDTH(3)) if1 ();
    adder_bist_if #(.WIDTH(3)) if0 ();
    adder_bist_if #(.WIDTH(3)) if3 ();

    always #5 clk = ~clk;

    adder_bist #(.WIDTH(3), .LAT(1), .ERR_W(8)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .dut(if1),
        .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1), .vec_idx(vec1),
        .fail_vec(fvec1), .fail_obs(fobs1)
    );
    adder_bist #(.WIDTH(3), .LAT(0), .ERR_W(8)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .dut(if0),
        .busy(busy0), .done(done0), .pass(pass0), .err_cnt(err0), .vec_idx(vec0),
        .fail_vec(fvec0), .fail_obs(fobs0)
    );
    adder_bist #(.WIDTH(3), .LAT(3), .ERR_W(8)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .dut(if3),
        .busy(busy3), .done(done3), .pass(pass3), .err_cnt(err3), .vec_idx(vec3),
        .fail_vec(fvec3), .fail_obs(fobs3)
    );

    function automatic logic [3:0] golden_of(input logic [6:0] v);
        return {1'b0, v[6:4]} + {1'b0, v[3:1]} + {3'b000, v[0]};
    endfunction

    // Adder model with optional planted faults
    function automatic logic [3:0] model_out(input int mode, input logic [6:0] v);
        logic [3:0] g;
        g = golden_of(v);
        case (mode)
            1:       return g & 4'b1110;
            2:       return g ^ 4'b1000;
            3:       return (v == 7'h2B) ? 4'h0 : g;
            default: return g;
        endcase
    endfunction

    // 1-cycle adder (may be faulty)
    always_ff @(posedge clk) begin
        {if1.dut_cout, if1.dut_sum} <= model_out(fault_mode, {if1.op_a, if1.op_b, if1.op_cin});
    end

    // Combinational adder
    always_comb begin
        {if0.dut_cout, if0.dut_sum} = model_out(0, {if0.op_a, if0.op_b, if0.op_cin});
    end

    // 3-cycle adder
    always_ff @(posedge clk) begin
        p1 <= model_out(0, {if3.op_a, if3.op_b, if3.op_cin});
        p2 <= p1;
        p3 <= p2;
    end
    assign {if3.dut_cout, if3.dut_sum} = p3;

    function automatic exp_t build_exp(input int mode, input int extra);
        exp_t       e;
        bit         found;
        logic [6:0] vv;
        logic [3:0] g, o;
        found  = 1'b0;
        e.err  = 0;
        e.fvec = '0;
        e.fobs = '0;
        for (int v = 0; v < 128; v++) begin
            vv = v[6:0];
            g  = golden_of(vv);
            o  = model_out(mode, vv);
            if (o != g) begin
                if (e.err < 255) e.err++;
                if (!found) begin
                    found  = 1'b1;
                    e.fvec = vv;
                    e.fobs = o;
                end
            end
        end
        e.pass = (e.err == 0);
`ifndef ADDER_BIST_FAIL_CAPTURE_EN
        e.fvec = '0;
        e.fobs = '0;
`endif
        e.cyc1 = 128 * 3 + extra;
        e.cyc0 = 128 * 2 + extra;
        e.cyc3 = 128 * 5 + extra;
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, busy1, 0);
        check({tag, "_done"}, done1, 0);
        check({tag, "_pass"}, pass1, 0);
        check({tag, "_err"}, err1, 0);
        check({tag, "_vec"}, vec1, 0);
        check({tag, "_ops"}, {if1.op_a, if1.op_b, if1.op_cin}, 0);
        check({tag, "_fail"}, {fvec1, fobs1}, 0);
        check({tag, "_busy0"}, busy0 | busy3 | done0 | done3, 0);
    endtask

    // One full run; expectations queued at start, popped when done is observed
    task automatic run(input string tag, input int mode, input int pause_at,
                       input int pulse_at, input int abort_at);
        exp_t       e;
        int         n, t1, t0, t3;
        bit         paused, pulsed, held;
        logic [6:0] hvec;
        logic [6:0] hops;
        fault_mode = mode;
        if (abort_at < 0) sb.push_back(build_exp(mode, (pause_at >= 0) ? 10 : 0));
        start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, "_busy_at_start"}, busy1, 1);
        check({tag, "_done_at_start"}, done1, 0);
        check({tag, "_err_at_start"}, err1, 0);
        n = 0; t1 = -1; t0 = -1; t3 = -1;
        paused = 1'b0; pulsed = 1'b0; held = 1'b1;
        while (n < 1000) begin
            tick();
            n++;
            start = 1'b0;
            if (done1 && t1 < 0) t1 = n;
            if (done0 && t0 < 0) t0 = n;
            if (done3 && t3 < 0) t3 = n;
            if (abort_at >= 0 && int'(vec1) == abort_at) begin
                rst_n = 1'b0;
                #1;
                check_all_zero({tag, "_abort"});
                tick();
                rst_n = 1'b1;
                tick();
                return;
            end
            if (pause_at >= 0 && !paused && int'(vec1) == pause_at) begin
                paused = 1'b1;
                ena    = 1'b0;
                hvec   = vec1;
                hops   = {if1.op_a, if1.op_b, if1.op_cin};
                for (int k = 0; k < 10; k++) begin
                    tick();
                    n++;
                    if (vec1 != hvec || {if1.op_a, if1.op_b, if1.op_cin} != hops || !busy1)
                        held = 1'b0;
                end
                ena = 1'b1;
                check({tag, "_ena_hold"}, held, 1);
            end
            if (pulse_at >= 0 && !pulsed && int'(vec1) == pulse_at) begin
                pulsed = 1'b1;
                start  = 1'b1;
            end
            if (t1 >= 0 && t0 >= 0 && t3 >= 0) break;
        end
        if (sb.size() == 0) begin
            check({tag, "_scoreboard_empty"}, 1, 0);
            return;
        end
        e = sb.pop_front();
        check({tag, "_done_cycle1"}, t1, e.cyc1);
        check({tag, "_done_cycle0"}, t0, e.cyc0);
        check({tag, "_done_cycle3"}, t3, e.cyc3);
        check({tag, "_err1"}, err1, e.err);
        check({tag, "_pass1"}, pass1, e.pass);
        check({tag, "_vec1"}, vec1, 127);
        check({tag, "_busy1"}, busy1, 0);
        check({tag, "_fail_vec"}, fvec1, e.fvec);
        check({tag, "_fail_obs"}, fobs1, e.fobs);
        check({tag, "_pass0_pass3"}, {pass0, pass3}, 2'b11);
        check({tag, "_err0_err3"}, {err0, err3}, 0);
        for (int k = 0; k < 5; k++) tick();
        check({tag, "_done_held"}, {done1, pass1, busy1}, {1'b1, e.pass, 1'b0});
    endtask

    initial begin
        #1;
        rst_n = 1'b0;
        tick();
        tick();
        check_all_zero("reset");
        rst_n = 1'b1;
        ena   = 1'b1;
        tick();
        run("clean", 0, -1, -1, -1);
        run("sum0_stuck", 1, -1, -1, -1);
        run("cout_inv", 2, -1, -1, -1);
        run("single_fault", 3, -1, -1, -1);
        run("ena_pause", 0, 40, 60, -1);
        run("abort", 0, -1, -1, 77);
        run("restart", 0, -1, -1, -1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
